// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

    // Default geometry of the register file.
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int FLAG_W   = 4;

    // Architectural register indices.
    localparam int SP_IDX = 13;
    localparam int LR_IDX = 14;
    localparam int PC_IDX = 15;

    // Flag bit positions, MSB first: N, Z, C, V.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Where a read port takes its value from, highest priority first.
    typedef enum logic [2:0] {
        SRC_WR1  = 3'd0,
        SRC_WR0  = 3'd1,
        SRC_PC   = 3'd2,
        SRC_ZERO = 3'd3,
        SRC_REG  = 3'd4
    } rd_src_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: write bypass, PC-with-offset, out-of-range zero.
module regfile_rdport #(
    parameter int DATA_W      = regfile_pkg::DATA_W,
    parameter int NUM_REGS    = regfile_pkg::NUM_REGS,
    parameter int PC_IDX      = regfile_pkg::PC_IDX,
    parameter int PC_READ_OFS = 8,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]     rd_sel,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_sel,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_sel,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [DATA_W-1:0] pc_value,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    output logic [DATA_W-1:0] rd_data
);
    import regfile_pkg::*;

    localparam logic [AW-1:0] PC_SEL     = AW'(PC_IDX);
    localparam logic [AW:0]   NUM_REGS_L = (AW+1)'(NUM_REGS);

    rd_src_e src;
    logic    sel_is_pc;

    assign sel_is_pc = (rd_sel == PC_SEL);

    // Pick the source by priority: wr1 bypass, wr0 bypass, PC, out of range, storage.
    always_comb begin
        src = SRC_REG;
        if (wr1_en && (wr1_sel == rd_sel)) begin
            src = SRC_WR1;
        end else if (wr0_en && (wr0_sel == rd_sel)) begin
            src = SRC_WR0;
        end else if (sel_is_pc) begin
            src = SRC_PC;
        end else if ({1'b0, rd_sel} >= NUM_REGS_L) begin
            src = SRC_ZERO;
        end
    end

    // Drive the data; a bypassed PC write shows the word-aligned value with no offset.
    always_comb begin
        rd_data = '0;
        case (src)
            SRC_WR1:  rd_data = sel_is_pc ? {wr1_data[DATA_W-1:2], 2'b00} : wr1_data;
            SRC_WR0:  rd_data = sel_is_pc ? {wr0_data[DATA_W-1:2], 2'b00} : wr0_data;
            SRC_PC:   rd_data = pc_value + DATA_W'(PC_READ_OFS);
            SRC_ZERO: rd_data = '0;
            SRC_REG:  rd_data = regs[rd_sel];
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, PC with auto-increment, masked flag register.
module regfile_mp #(
    parameter int DATA_W      = regfile_pkg::DATA_W,
    parameter int NUM_REGS    = regfile_pkg::NUM_REGS,
    parameter int NUM_RD      = 2,
    parameter int PC_IDX      = regfile_pkg::PC_IDX,
    parameter int PC_STEP     = 4,
    parameter int PC_READ_OFS = 8,
    parameter int RESET_PC    = 0,
    parameter int FLAG_W      = regfile_pkg::FLAG_W,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_sel,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_sel,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NUM_RD*AW-1:0]     rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     pc_inc,
    output logic [DATA_W-1:0]        pc_out,
    input  logic [FLAG_W-1:0]        flags_we,
    input  logic [FLAG_W-1:0]        flags_in,
    output logic [FLAG_W-1:0]        flags_out
);
    import regfile_pkg::*;

    localparam logic [AW-1:0] PC_SEL = AW'(PC_IDX);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic [DATA_W-1:0] pc_reg;
    logic [DATA_W-1:0] pc_next;
    logic [FLAG_W-1:0] flags_reg;
    logic              wr0_act;
    logic              wr1_act;
    logic              wr0_pc;
    logic              wr1_pc;

    // Writes held off during reset must not bypass either.
    assign wr0_act = wr0_en & reset_n;
    assign wr1_act = wr1_en & reset_n;
    assign wr0_pc  = wr0_en && (wr0_sel == PC_SEL);
    assign wr1_pc  = wr1_en && (wr1_sel == PC_SEL);

    // General-purpose storage; the PC slot is never written here, it lives in pc_reg.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i != PC_IDX) begin
                    if (wr1_en && (wr1_sel == AW'(i))) begin
                        regs_reg[i] <= wr1_data;
                    end else if (wr0_en && (wr0_sel == AW'(i))) begin
                        regs_reg[i] <= wr0_data;
                    end
                end
            end
        end
    end

    // PC next value: explicit write (wr1 first, aligned) beats increment beats hold.
    always_comb begin
        pc_next = pc_reg;
        if (wr1_pc) begin
            pc_next = {wr1_data[DATA_W-1:2], 2'b00};
        end else if (wr0_pc) begin
            pc_next = {wr0_data[DATA_W-1:2], 2'b00};
        end else if (pc_inc) begin
            pc_next = pc_reg + DATA_W'(PC_STEP);
        end
    end

    // PC register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg <= DATA_W'(RESET_PC);
        end else begin
            pc_reg <= pc_next;
        end
    end

    // Flag register: each bit loads only where its write-mask bit is set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_reg <= '0;
        end else begin
            flags_reg <= (flags_reg & ~flags_we) | (flags_in & flags_we);
        end
    end

    assign pc_out    = pc_reg;
    assign flags_out = flags_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rdport #(
                .DATA_W      (DATA_W),
                .NUM_REGS    (NUM_REGS),
                .PC_IDX      (PC_IDX),
                .PC_READ_OFS (PC_READ_OFS)
            ) u_rdport (
                .rd_sel   (rd_sel[gi*AW +: AW]),
                .wr0_en   (wr0_act),
                .wr0_sel  (wr0_sel),
                .wr0_data (wr0_data),
                .wr1_en   (wr1_act),
                .wr1_sel  (wr1_sel),
                .wr1_data (wr1_data),
                .pc_value (pc_reg),
                .regs     (regs_reg),
                .rd_data  (rd_data[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vectors plus a per-cycle reference model.
module tb_regfile_mp;

    logic        clock;
    logic        reset_n;
    logic        wr0_en;
    logic [3:0]  wr0_sel;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [3:0]  wr1_sel;
    logic [31:0] wr1_data;
    logic [7:0]  rd_sel;
    logic [63:0] rd_data;
    logic        pc_inc;
    logic [31:0] pc_out;
    logic [3:0]  flags_we;
    logic [3:0]  flags_in;
    logic [3:0]  flags_out;

    // Second instance built with only 12 registers for the out-of-range cases.
    logic        d2_wr0_en;
    logic [3:0]  d2_wr0_sel;
    logic [31:0] d2_wr0_data;
    logic        d2_wr1_en;
    logic [3:0]  d2_wr1_sel;
    logic [31:0] d2_wr1_data;
    logic [7:0]  d2_rd_sel;
    logic [63:0] d2_rd_data;
    logic [31:0] d2_pc_out;
    logic [3:0]  d2_flags_out;

    int checks   = 0;
    int failures = 0;

    regfile_mp dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr0_en    (wr0_en),
        .wr0_sel   (wr0_sel),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_sel   (wr1_sel),
        .wr1_data  (wr1_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .pc_inc    (pc_inc),
        .pc_out    (pc_out),
        .flags_we  (flags_we),
        .flags_in  (flags_in),
        .flags_out (flags_out)
    );

    regfile_mp #(.NUM_REGS(12)) dut12 (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr0_en    (d2_wr0_en),
        .wr0_sel   (d2_wr0_sel),
        .wr0_data  (d2_wr0_data),
        .wr1_en    (d2_wr1_en),
        .wr1_sel   (d2_wr1_sel),
        .wr1_data  (d2_wr1_data),
        .rd_sel    (d2_rd_sel),
        .rd_data   (d2_rd_data),
        .pc_inc    (1'b0),
        .pc_out    (d2_pc_out),
        .flags_we  (4'b0000),
        .flags_in  (4'b0000),
        .flags_out (d2_flags_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_regs [16];
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= 32'h0;
            m_pc    <= 32'h0;
            m_flags <= 4'h0;
        end else begin
            if (wr0_en) m_regs[wr0_sel] <= wr0_data;
            if (wr1_en) m_regs[wr1_sel] <= wr1_data;
            if (wr1_en && wr1_sel == 4'd15)      m_pc <= wr1_data & 32'hFFFF_FFFC;
            else if (wr0_en && wr0_sel == 4'd15) m_pc <= wr0_data & 32'hFFFF_FFFC;
            else if (pc_inc)                     m_pc <= m_pc + 32'd4;
            for (int i = 0; i < 4; i++)
                if (flags_we[i]) m_flags[i] <= flags_in[i];
        end
    end

    function automatic logic [31:0] m_read(input logic [3:0] s);
        logic [31:0] v;
        if (reset_n && wr1_en && wr1_sel == s)      v = wr1_data;
        else if (reset_n && wr0_en && wr0_sel == s) v = wr0_data;
        else if (s == 4'd15)                        return m_pc + 32'd8;
        else                                        return m_regs[s];
        return (s == 4'd15) ? (v & 32'hFFFF_FFFC) : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp,
                       input bit verbose);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end else if (verbose) begin
            $display("txn %s value=%08h ok", name, got);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("cyc_pc_out", pc_out, m_pc, 1'b0);
        chk("cyc_flags", {28'h0, flags_out}, {28'h0, m_flags}, 1'b0);
        chk("cyc_rd0", rd_data[31:0], m_read(rd_sel[3:0]), 1'b0);
        chk("cyc_rd1", rd_data[63:32], m_read(rd_sel[7:4]), 1'b0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_writes();
        wr0_en = 1'b0; wr1_en = 1'b0; pc_inc = 1'b0; flags_we = 4'b0000;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with every update source active.
        reset_n  = 1'b0;
        pc_inc   = 1'b1;
        wr0_en   = 1'b1; wr0_sel = 4'd0; wr0_data = 32'hFFFF_FFFF;
        wr1_en   = 1'b1; wr1_sel = 4'd1; wr1_data = 32'hEEEE_EEEE;
        flags_we = 4'b1111; flags_in = 4'b1111;
        rd_sel   = {4'd1, 4'd0};
        d2_wr0_en = 1'b0; d2_wr0_sel = 4'd0; d2_wr0_data = 32'h0;
        d2_wr1_en = 1'b0; d2_wr1_sel = 4'd0; d2_wr1_data = 32'h0;
        d2_rd_sel = 8'h00;
        tick(); tick(); tick();
        chk("reset_pc_out", pc_out, 32'h0, 1'b1);
        chk("reset_flags", {28'h0, flags_out}, 32'h0, 1'b1);
        chk("reset_rd0", rd_data[31:0], 32'h0, 1'b1);
        chk("reset_rd1", rd_data[63:32], 32'h0, 1'b1);

        // Release reset with pc_inc set: one increment on the next edge.
        idle_writes();
        reset_n = 1'b1;
        pc_inc  = 1'b1;
        tick();
        pc_inc = 1'b0;
        chk("pc_after_inc", pc_out, 32'h4, 1'b1);

        // Write then read.
        wr0_en = 1'b1; wr0_sel = 4'd0; wr0_data = 32'h1234_5678;
        tick();
        wr0_sel = 4'd1; wr0_data = 32'h8765_4321;
        tick();
        idle_writes();
        rd_sel = {4'd1, 4'd0};
        #2;
        chk("read_r0", rd_data[31:0], 32'h1234_5678, 1'b1);
        chk("read_r1", rd_data[63:32], 32'h8765_4321, 1'b1);

        // Same-index collision: wr1 wins on bypass and in storage.
        wr0_en = 1'b1; wr0_sel = 4'd3; wr0_data = 32'hAAAA_0000;
        wr1_en = 1'b1; wr1_sel = 4'd3; wr1_data = 32'h5555_FFFF;
        rd_sel = {4'd0, 4'd3};
        #2;
        chk("collide_bypass", rd_data[31:0], 32'h5555_FFFF, 1'b1);
        tick();
        idle_writes();
        #2;
        chk("collide_stored", rd_data[31:0], 32'h5555_FFFF, 1'b1);

        // Independent writes on both ports, each bypassed to its own read port.
        wr0_en = 1'b1; wr0_sel = 4'd7; wr0_data = 32'h1111_1111;
        wr1_en = 1'b1; wr1_sel = 4'd8; wr1_data = 32'h2222_2222;
        rd_sel = {4'd8, 4'd7};
        #2;
        chk("dual_bypass0", rd_data[31:0], 32'h1111_1111, 1'b1);
        chk("dual_bypass1", rd_data[63:32], 32'h2222_2222, 1'b1);
        tick();
        idle_writes();

        // PC write beats pc_inc; bypass shows aligned value, storage read adds offset.
        wr0_en = 1'b1; wr0_sel = 4'd15; wr0_data = 32'hABCD_1237;
        pc_inc = 1'b1;
        rd_sel = {4'd15, 4'd0};
        #2;
        chk("pc_bypass_aligned", rd_data[63:32], 32'hABCD_1234, 1'b1);
        tick();
        idle_writes();
        chk("pc_write_wins", pc_out, 32'hABCD_1234, 1'b1);
        rd_sel = {4'd0, 4'd15};
        #2;
        chk("pc_read_ofs", rd_data[31:0], 32'hABCD_123C, 1'b1);

        // PC wrap.
        wr1_en = 1'b1; wr1_sel = 4'd15; wr1_data = 32'hFFFF_FFFC;
        tick();
        idle_writes();
        chk("pc_load_top", pc_out, 32'hFFFF_FFFC, 1'b1);
        #1;
        chk("pc_read_wrap", rd_data[31:0], 32'h0000_0004, 1'b1);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        chk("pc_inc_wrap", pc_out, 32'h0, 1'b1);

        // Masked flag updates.
        flags_we = 4'b1100; flags_in = 4'b1111;
        tick();
        chk("flags_hi", {28'h0, flags_out}, 32'hC, 1'b1);
        flags_we = 4'b0011; flags_in = 4'b0001;
        tick();
        flags_we = 4'b0000;
        chk("flags_lo", {28'h0, flags_out}, 32'hD, 1'b1);

        // Asynchronous reset mid-cycle clears state without an edge.
        rd_sel = {4'd15, 4'd0};
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_pc", pc_out, 32'h0, 1'b1);
        chk("async_flags", {28'h0, flags_out}, 32'h0, 1'b1);
        chk("async_r0", rd_data[31:0], 32'h0, 1'b1);
        chk("async_pc_read", rd_data[63:32], 32'h8, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();

        // 12-register build: write to an out-of-range index changes nothing.
        d2_wr0_en = 1'b1; d2_wr0_sel = 4'd5; d2_wr0_data = 32'h0000_0055;
        tick();
        d2_wr0_sel = 4'd13; d2_wr0_data = 32'hDEAD_DEAD;
        d2_wr1_en = 1'b1; d2_wr1_sel = 4'd13; d2_wr1_data = 32'hBEEF_BEEF;
        tick();
        d2_wr0_en = 1'b0; d2_wr1_en = 1'b0;
        for (int s = 0; s < 12; s++) begin
            d2_rd_sel = {4'd13, 4'(s)};
            #1;
            chk($sformatf("r12_reg%0d", s), d2_rd_data[31:0],
                (s == 5) ? 32'h0000_0055 : 32'h0, 1'b1);
            chk($sformatf("r12_oor%0d", s), d2_rd_data[63:32], 32'h0, 1'b1);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
